// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for MULT/MULTU.
// Produces a 2*WIDTH product into HI/LO WIDTH edges after start, with a registered busy/done handshake.

module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_sum;
    logic [2*WIDTH-1:0] w_result;

    // The DONE exit edge doubles as the earliest acceptance edge, so a held
    // start yields one product every WIDTH+1 cycles.
    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_state == S_RUN) && (r_count == CW'(1));

    // Signed operands are reduced to magnitudes; -2^(WIDTH-1) maps onto itself as unsigned.
    assign w_abs_a  = (i_is_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
    assign w_abs_b  = (i_is_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

    assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_result = r_neg ? (~w_sum + (2*WIDTH)'(1)) : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                r_mplier <= w_abs_b;
                r_neg    <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_acc    <= '0;
                r_count  <= CW'(WIDTH);
            end else if (r_state == S_RUN) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count - CW'(1);
                if (w_last) begin
                    {r_hi, r_lo} <= w_result;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: self-checking bench for mult_unit against a cycle-level behavioural model.
// Directed test-plan cases with literal results, then randomized operand/start traffic.

module tb_mult_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_is_signed(is_signed),
        .i_a        (a),
        .i_b        (b),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y,
                                                input logic s);
        longint          sx, sy;
        longint unsigned ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = 64'(x);
        uy = 64'(y);
        return ux * uy;
    endfunction

    // Behavioural model: remaining edges of the running op, done flag, last result.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_res  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res  = m_prod;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_prod = ref_product(a, b, is_signed);
                m_left = W;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("busy", 64'(busy), 64'(m_left > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_res[63:32]));
            check("lo", 64'(lo), 64'(m_res[31:0]));
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    int done_at;
    int busy_cnt;
    int pulses;
    int d1;
    int d2;

    // One start pulse; waits (bounded) for done and checks the fixed latency.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        @(negedge clk);
        a = x;
        b = y;
        is_signed = s;
        start = 1'b1;
        done_at = -1;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                a = $urandom;
                b = $urandom;
                is_signed = 1'($urandom_range(0, 1));
            end
            busy_cnt += int'(busy);
            if (done) begin
                done_at = i;
                break;
            end
        end
        check("done_latency", 64'(done_at), 64'd32);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        check("model_s_m3x5", ref_product(32'hFFFF_FFFD, 32'd5, 1'b1), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_u_max", ref_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        check("model_s_min", ref_product(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

        run_op(32'd7, 32'd6, 1'b0);
        check("u7x6_busy_cycles", 64'(busy_cnt), 64'd32);
        check("u7x6_hi", 64'(hi), 64'h0);
        check("u7x6_lo", 64'(lo), 64'h2A);

        run_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        check("s_m3x5_hi", 64'(hi), 64'hFFFF_FFFF);
        check("s_m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b0);
        check("u_m3x5_hi", 64'(hi), 64'h0000_0004);
        check("u_m3x5_lo", 64'(lo), 64'hFFFF_FFF1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("u_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("u_max_lo", 64'(lo), 64'h0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        check("s_min2_hi", 64'(hi), 64'h4000_0000);
        check("s_min2_lo", 64'(lo), 64'h0000_0000);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        check("s_minx1_hi", 64'(hi), 64'hFFFF_FFFF);
        check("s_minx1_lo", 64'(lo), 64'h8000_0000);

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        a = 32'd100;
        b = 32'd3;
        is_signed = 1'b0;
        start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 4) begin
                start = 1'b1;
                a = 32'd9;
                b = 32'd9;
            end
            if (i == 5) start = 1'b0;
            pulses += int'(done);
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_hi", 64'(hi), 64'h0);
        check("ignore_lo", 64'(lo), 64'h12C);

        // Start held high: back-to-back operations.
        @(negedge clk);
        a = 32'd5;
        b = 32'd5;
        is_signed = 1'b0;
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i <= 65; i++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
        end
        start = 1'b0;
        check("b2b_done1", 64'(d1), 64'd32);
        check("b2b_done2", 64'(d2), 64'd65);
        check("b2b_lo", 64'(lo), 64'd25);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 32'h1234;
        b = 32'h10;
        start = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd2, 32'd2, 1'b0);
        check("post_rst_hi", 64'(hi), 64'd0);
        check("post_rst_lo", 64'(lo), 64'd4);

        // Result hold across idle cycles with toggling operands.
        run_op(32'd6, 32'd7, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            pulses += int'(done);
        end
        check("hold_pulses", 64'(pulses), 64'd0);
        check("hold_hi", 64'(hi), 64'd0);
        check("hold_lo", 64'(lo), 64'd42);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = pick();
            b = pick();
            is_signed = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
